// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if
// Bundles every non-clock, non-reset signal between the multicycle
// controller and the datapath around it.
//   master modport : controller side (samples run/fetch/memory status, drives
//                    phase, IR fields, datapath selects/enables, counters)
//   slave modport  : datapath side (the mirror image)
// Parameters mirror the controller: REG_AW register address width, IMM_W
// immediate width, CNT_W retired-instruction counter width.
interface multicycle_ctrl_if #(
    parameter int REG_AW = 4,
    parameter int IMM_W  = 8,
    parameter int CNT_W  = 16
);
    localparam int INSTR_W = 4 + REG_AW + IMM_W;

    // run request and fetch handshake
    logic                 enable;
    logic [INSTR_W-1:0]   instr;
    logic                 instr_valid;
    logic                 ir_load;
    // datapath status
    logic                 alu_out0;
    logic                 mem_ready;
    // sequencer and IR fields
    logic [4:0]           phase;
    logic [REG_AW-1:0]    reg_a;
    logic [REG_AW-1:0]    reg_b;
    logic [IMM_W-1:0]     imm;
    logic [INSTR_W-5:0]   jump_target;
    // datapath controls
    logic                 reg_r_enable;
    logic                 reg_w_enable;
    logic                 alu_mux;
    logic                 sign_mux;
    logic                 write_data_mux;
    logic                 disp_enable;
    logic                 mem_r_enable;
    logic                 mem_w_enable;
    logic [2:0]           pc_enables;
    logic [3:0]           alu_op;
    // retirement
    logic                 instr_done;
    logic [CNT_W-1:0]     retired_count;

    modport master (
        input  enable, instr, instr_valid, alu_out0, mem_ready,
        output ir_load, phase, reg_a, reg_b, imm, jump_target,
               reg_r_enable, reg_w_enable, alu_mux, sign_mux, write_data_mux,
               disp_enable, mem_r_enable, mem_w_enable, pc_enables, alu_op,
               instr_done, retired_count
    );

    modport slave (
        output enable, instr, instr_valid, alu_out0, mem_ready,
        input  ir_load, phase, reg_a, reg_b, imm, jump_target,
               reg_r_enable, reg_w_enable, alu_mux, sign_mux, write_data_mux,
               disp_enable, mem_r_enable, mem_w_enable, pc_enables, alu_op,
               instr_done, retired_count
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Multicycle control unit for the custom RISC datapath. A one-hot phase
// sequencer (IDLE/FETCH/DECODE/EXEC/MEM/WB) steps each instruction through
// the datapath; an instruction register is loaded through a fetch handshake,
// loads/stores wait on mem_ready, branches use a flag captured from the ALU in
// EXEC, and a wrapping counter tracks retired instructions.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : multicycle_ctrl_if.master -- all handshake, status and control
//           signals (see interface file)
// Every control output is decoded from the registered phase and IR only,
// except ir_load which also follows instr_valid during FETCH.
module multicycle_ctrl #(
    parameter int REG_AW = 4,
    parameter int IMM_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_ctrl_if.master      bus
);
    localparam int INSTR_W = 4 + REG_AW + IMM_W;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_SRLI  = 4'h8;
    localparam logic [3:0] OP_DISP  = 4'h9;
    localparam logic [3:0] OP_BEQZ  = 4'hA;
    localparam logic [3:0] OP_BLTZ  = 4'hC;
    localparam logic [3:0] OP_LW    = 4'hD;
    localparam logic [3:0] OP_SW    = 4'hE;
    localparam logic [3:0] OP_JUMP  = 4'hF;

    // The state code is the phase output itself, so phase needs no decode.
    typedef enum logic [4:0] {
        S_IDLE   = 5'b00000,
        S_FETCH  = 5'b10000,
        S_DECODE = 5'b01000,
        S_EXEC   = 5'b00100,
        S_MEM    = 5'b00010,
        S_WB     = 5'b00001
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [INSTR_W-1:0]  ir_r;
    logic                cond_flag_r;
    logic [CNT_W-1:0]    retired_count_r;

    logic [3:0]          opcode_s;
    logic [3:0]          rcode_s;
    logic                is_branch_s;
    logic                is_mem_op_s;

    logic                ir_load_s;
    logic                reg_r_enable_s;
    logic                reg_w_enable_s;
    logic                alu_mux_s;
    logic                sign_mux_s;
    logic                write_data_mux_s;
    logic                disp_enable_s;
    logic                mem_r_enable_s;
    logic                mem_w_enable_s;
    logic [2:0]          pc_enables_s;
    logic [3:0]          alu_op_s;
    logic                instr_done_s;

    // ALU operation for each opcode; R-type passes the rcode field through.
    function automatic logic [3:0] decode_alu_op(input logic [3:0] op,
                                                 input logic [3:0] rcode);
        logic [3:0] res;
        case (op)
            4'h0:    res = rcode;
            4'h1:    res = 4'b0001;
            4'h2:    res = 4'b0000;
            4'h3:    res = 4'b1100;
            4'h4:    res = 4'b1101;
            4'h5:    res = 4'b1110;
            4'h6:    res = 4'b0111;
            4'h7:    res = 4'b0110;
            4'h8:    res = 4'b1001;
            4'h9:    res = 4'b1010;
            4'hA:    res = 4'b0101;
            4'hB:    res = 4'b0100;
            4'hC:    res = 4'b1011;
            default: res = 4'b0000;   // lw, sw, jump
        endcase
        return res;
    endfunction

    assign opcode_s    = ir_r[INSTR_W-1 -: 4];
    assign rcode_s     = ir_r[3:0];
    assign is_branch_s = (opcode_s >= OP_BEQZ) && (opcode_s <= OP_BLTZ);
    assign is_mem_op_s = (opcode_s == OP_LW) || (opcode_s == OP_SW);

    // Phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-phase decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE:   state_next_s = bus.enable ? S_FETCH : S_IDLE;
            S_FETCH:  state_next_s = bus.instr_valid ? S_DECODE : S_FETCH;
            S_DECODE: state_next_s = S_EXEC;
            S_EXEC:   state_next_s = S_MEM;
            // Only loads/stores wait for the memory; everything else passes.
            S_MEM: begin
                if (is_mem_op_s && !bus.mem_ready) begin
                    state_next_s = S_MEM;
                end else begin
                    state_next_s = S_WB;
                end
            end
            S_WB:     state_next_s = bus.enable ? S_FETCH : S_IDLE;
            default:  state_next_s = S_IDLE;
        endcase
    end

    // Instruction register and branch condition flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_r        <= '0;
            cond_flag_r <= 1'b0;
        end else begin
            if (state_r == S_FETCH && bus.instr_valid) begin
                ir_r <= bus.instr;
            end
            if (state_r == S_EXEC) begin
                cond_flag_r <= bus.alu_out0;
            end
        end
    end

    // Retired-instruction counter. It steps on the edge that enters WB so the
    // new count is already visible alongside instr_done; an instruction
    // aborted by reset before WB is never counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_count_r <= '0;
        end else if (state_r == S_MEM && state_next_s == S_WB) begin
            retired_count_r <= retired_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retired_count_r <= retired_count_r;
        end
    end

    // Control outputs from phase and IR.
    always_comb begin
        ir_load_s        = 1'b0;
        reg_r_enable_s   = 1'b0;
        reg_w_enable_s   = 1'b0;
        alu_mux_s        = 1'b0;
        sign_mux_s       = 1'b0;
        write_data_mux_s = 1'b0;
        disp_enable_s    = 1'b0;
        mem_r_enable_s   = 1'b0;
        mem_w_enable_s   = 1'b0;
        pc_enables_s     = 3'b000;
        alu_op_s         = 4'b0000;
        instr_done_s     = 1'b0;
        // ALU selects are held stable from DECODE through WB.
        if (state_r == S_DECODE || state_r == S_EXEC ||
            state_r == S_MEM    || state_r == S_WB) begin
            alu_op_s   = decode_alu_op(opcode_s, rcode_s);
            alu_mux_s  = (opcode_s >= 4'h1) && (opcode_s <= OP_BLTZ);
            sign_mux_s = !is_branch_s;
        end else begin
            alu_op_s   = 4'b0000;
            alu_mux_s  = 1'b0;
            sign_mux_s = 1'b0;
        end
        case (state_r)
            S_IDLE: begin
                ir_load_s = 1'b0;
            end
            S_FETCH: begin
                ir_load_s = bus.instr_valid;
            end
            S_DECODE: begin
                reg_r_enable_s = (opcode_s != OP_JUMP);
            end
            S_EXEC: begin
                ir_load_s = 1'b0;
            end
            S_MEM: begin
                mem_r_enable_s = (opcode_s == OP_LW);
                mem_w_enable_s = (opcode_s == OP_SW);
            end
            S_WB: begin
                instr_done_s     = 1'b1;
                reg_w_enable_s   = (opcode_s <= OP_SRLI) || (opcode_s == OP_LW);
                write_data_mux_s = (opcode_s == OP_LW);
                disp_enable_s    = (opcode_s == OP_DISP);
                if (is_branch_s) begin
                    pc_enables_s = cond_flag_r ? 3'b100 : 3'b010;
                end else if (opcode_s == OP_JUMP) begin
                    pc_enables_s = 3'b001;
                end else begin
                    pc_enables_s = 3'b010;
                end
            end
            default: begin
                ir_load_s = 1'b0;
            end
        endcase
    end

    assign bus.phase          = state_r;
    assign bus.ir_load        = ir_load_s;
    assign bus.reg_a          = ir_r[INSTR_W-5 -: REG_AW];
    assign bus.reg_b          = ir_r[INSTR_W-5-REG_AW -: REG_AW];
    assign bus.imm            = ir_r[IMM_W-1:0];
    assign bus.jump_target    = ir_r[INSTR_W-5:0];
    assign bus.reg_r_enable   = reg_r_enable_s;
    assign bus.reg_w_enable   = reg_w_enable_s;
    assign bus.alu_mux        = alu_mux_s;
    assign bus.sign_mux       = sign_mux_s;
    assign bus.write_data_mux = write_data_mux_s;
    assign bus.disp_enable    = disp_enable_s;
    assign bus.mem_r_enable   = mem_r_enable_s;
    assign bus.mem_w_enable   = mem_w_enable_s;
    assign bus.pc_enables     = pc_enables_s;
    assign bus.alu_op         = alu_op_s;
    assign bus.instr_done     = instr_done_s;
    assign bus.retired_count  = retired_count_r;

    // The opcode class constant is kept for readability of the decode table.
    logic unused_rtype_s;
    assign unused_rtype_s = (OP_RTYPE == 4'h0);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
// Directed bench for multicycle_ctrl: each instruction from the test plan is
// stepped phase by phase, outputs are sampled 1 ns after the rising edge and
// compared with hand-computed values.
module tb_multicycle_ctrl;
    localparam logic [4:0] PH_IDLE   = 5'b00000;
    localparam logic [4:0] PH_FETCH  = 5'b10000;
    localparam logic [4:0] PH_DECODE = 5'b01000;
    localparam logic [4:0] PH_EXEC   = 5'b00100;
    localparam logic [4:0] PH_MEM    = 5'b00010;
    localparam logic [4:0] PH_WB     = 5'b00001;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    multicycle_ctrl_if #(.REG_AW(4), .IMM_W(8), .CNT_W(16)) bus ();

    multicycle_ctrl #(.REG_AW(4), .IMM_W(8), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it when it differs.
    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass = n_pass + 1;
        end
    endtask

    // Advance one clock and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Step from WB/IDLE through FETCH..MEM to WB (no memory wait).
    task automatic run_to_wb();
        for (int i = 0; i < 5; i++) begin
            tick();
        end
    endtask

    initial begin
        int cyc;
        int rcnt;
        int low;
        n_checks         = 0;
        n_pass           = 0;
        rst_n            = 1'b0;
        bus.enable       = 1'b0;
        bus.instr        = 16'h0000;
        bus.instr_valid  = 1'b0;
        bus.alu_out0     = 1'b0;
        bus.mem_ready    = 1'b0;

        // Reset state
        #12;
        check("rst_phase",   32'(bus.phase), 32'h0);
        check("rst_ir_load", 32'(bus.ir_load), 32'h0);
        check("rst_pc",      32'(bus.pc_enables), 32'h0);
        check("rst_done",    32'(bus.instr_done), 32'h0);
        check("rst_alu_op",  32'(bus.alu_op), 32'h0);
        check("rst_count",   32'(bus.retired_count), 32'h0);
        check("rst_jt",      32'(bus.jump_target), 32'h0);
        rst_n = 1'b1;
        tick();
        check("idle_hold", 32'(bus.phase), 32'(PH_IDLE));

        // addi r3,5 ; mem_ready high outside lw/sw must be ignored
        bus.enable      = 1'b1;
        bus.instr       = 16'h1305;
        bus.instr_valid = 1'b1;
        bus.mem_ready   = 1'b1;
        tick();
        check("addi_fetch",   32'(bus.phase), 32'(PH_FETCH));
        check("addi_ir_load", 32'(bus.ir_load), 32'h1);
        check("addi_f_aluop", 32'(bus.alu_op), 32'h0);
        tick();
        check("addi_decode", 32'(bus.phase), 32'(PH_DECODE));
        check("addi_rre",    32'(bus.reg_r_enable), 32'h1);
        check("addi_reg_a",  32'(bus.reg_a), 32'h3);
        check("addi_imm",    32'(bus.imm), 32'h05);
        tick();
        check("addi_exec",    32'(bus.phase), 32'(PH_EXEC));
        check("addi_alu_op",  32'(bus.alu_op), 32'h1);
        check("addi_alu_mux", 32'(bus.alu_mux), 32'h1);
        check("addi_sign",    32'(bus.sign_mux), 32'h1);
        check("addi_e_rre",   32'(bus.reg_r_enable), 32'h0);
        tick();
        check("addi_mem",  32'(bus.phase), 32'(PH_MEM));
        check("addi_mre",  32'(bus.mem_r_enable), 32'h0);
        tick();
        check("addi_wb",    32'(bus.phase), 32'(PH_WB));
        check("addi_rwe",   32'(bus.reg_w_enable), 32'h1);
        check("addi_pc",    32'(bus.pc_enables), 32'b010);
        check("addi_done",  32'(bus.instr_done), 32'h1);
        check("addi_count", 32'(bus.retired_count), 32'h1);
        check("addi_wdm",   32'(bus.write_data_mux), 32'h0);

        // beqz r2 taken
        bus.instr    = 16'hA200;
        bus.alu_out0 = 1'b1;
        tick(); tick(); tick();
        check("beqz_exec_sign", 32'(bus.sign_mux), 32'h0);
        check("beqz_alu_op",    32'(bus.alu_op), 32'b0101);
        tick();
        bus.alu_out0 = 1'b0;   // flag was captured leaving EXEC
        tick();
        check("beqz_t_wb",  32'(bus.phase), 32'(PH_WB));
        check("beqz_t_pc",  32'(bus.pc_enables), 32'b100);
        check("beqz_t_rwe", 32'(bus.reg_w_enable), 32'h0);
        check("beqz_count", 32'(bus.retired_count), 32'h2);

        // beqz r2 not taken
        run_to_wb();
        check("beqz_n_pc",  32'(bus.pc_enables), 32'b010);
        check("beqz_n_done", 32'(bus.instr_done), 32'h1);

        // lw r1,(r4) with mem_ready low for three MEM cycles
        bus.instr     = 16'hD140;
        bus.mem_ready = 1'b0;
        tick();
        check("lw_fetch", 32'(bus.phase), 32'(PH_FETCH));
        cyc  = 1;
        rcnt = 0;
        low  = 0;
        while (!bus.instr_done && cyc < 30) begin
            if (bus.phase == PH_DECODE) begin
                check("lw_reg_b", 32'(bus.reg_b), 32'h4);
            end
            if (bus.mem_r_enable) rcnt++;
            if (bus.phase == PH_MEM) begin
                if (low < 3) begin
                    bus.mem_ready = 1'b0;
                    low++;
                end else begin
                    bus.mem_ready = 1'b1;
                end
            end
            tick();
            cyc++;
        end
        check("lw_done",   32'(bus.instr_done), 32'h1);
        check("lw_cycles", 32'(cyc), 32'd8);
        check("lw_mre_cy", 32'(rcnt), 32'd4);
        check("lw_wdm",    32'(bus.write_data_mux), 32'h1);
        check("lw_rwe",    32'(bus.reg_w_enable), 32'h1);
        check("lw_wb_mre", 32'(bus.mem_r_enable), 32'h0);

        // jump 0x123
        bus.instr = 16'hF123;
        tick(); tick();
        check("jmp_decode", 32'(bus.phase), 32'(PH_DECODE));
        check("jmp_target", 32'(bus.jump_target), 32'h123);
        check("jmp_rre",    32'(bus.reg_r_enable), 32'h0);
        tick(); tick(); tick();
        check("jmp_pc",  32'(bus.pc_enables), 32'b001);
        check("jmp_rwe", 32'(bus.reg_w_enable), 32'h0);

        // disp r5
        bus.instr = 16'h9500;
        run_to_wb();
        check("disp_de",     32'(bus.disp_enable), 32'h1);
        check("disp_alu_op", 32'(bus.alu_op), 32'b1010);
        check("disp_rwe",    32'(bus.reg_w_enable), 32'h0);
        check("disp_count",  32'(bus.retired_count), 32'h6);

        // movi r7 with instr_valid low for two FETCH cycles, enable dropped in EXEC
        bus.instr       = 16'h2700;
        bus.instr_valid = 1'b0;
        tick();
        check("stall1_phase", 32'(bus.phase), 32'(PH_FETCH));
        check("stall1_load",  32'(bus.ir_load), 32'h0);
        check("stall1_ra",    32'(bus.reg_a), 32'h5);
        tick();
        check("stall2_phase", 32'(bus.phase), 32'(PH_FETCH));
        check("stall2_ra",    32'(bus.reg_a), 32'h5);
        bus.instr_valid = 1'b1;
        #1;
        check("stall_load", 32'(bus.ir_load), 32'h1);
        tick();
        check("movi_ra", 32'(bus.reg_a), 32'h7);
        tick();
        check("movi_exec", 32'(bus.phase), 32'(PH_EXEC));
        bus.enable = 1'b0;
        tick(); tick();
        check("movi_wb",    32'(bus.phase), 32'(PH_WB));
        check("movi_rwe",   32'(bus.reg_w_enable), 32'h1);
        check("movi_count", 32'(bus.retired_count), 32'h7);
        tick();
        check("movi_idle", 32'(bus.phase), 32'(PH_IDLE));
        check("movi_pc0",  32'(bus.pc_enables), 32'h0);
        tick();
        check("idle_stay", 32'(bus.phase), 32'(PH_IDLE));

        // sw r3,(r4) aborted by reset in MEM
        bus.enable    = 1'b1;
        bus.instr     = 16'hE340;
        bus.mem_ready = 1'b0;
        tick(); tick(); tick(); tick();
        check("sw_mem", 32'(bus.phase), 32'(PH_MEM));
        check("sw_mwe", 32'(bus.mem_w_enable), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("sw_rst_mwe",   32'(bus.mem_w_enable), 32'h0);
        check("sw_rst_phase", 32'(bus.phase), 32'(PH_IDLE));
        check("sw_rst_count", 32'(bus.retired_count), 32'h0);
        bus.enable = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", 32'(bus.phase), 32'(PH_IDLE));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multicycle control unit for the custom RISC datapath. It carries its own one-hot phase sequencer, an instruction register with a fetch handshake, load/store support with a memory wait handshake, jump handling and a retired-instruction counter. It sits between the program memory/PC block and the register file, ALU, sign extender, data memory and display. It drives all datapath selects and enables from its registered state and instruction register.

## Interface
- REG_AW, default 4: register address width.
- IMM_W, default 8: immediate width. Must be ≥ REG_AW+4. INSTR_W = 4+REG_AW+IMM_W (default 16).
- CNT_W, default 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  run request; sampled only in IDLE and at the end of WB.
- instr  in  INSTR_W  instruction from program memory.
- instr_valid  in  1  instr is valid this cycle.
- alu_out0  in  1  ALU result bit 0 (branch condition).
- mem_ready  in  1  data memory has completed the access.
- phase  out  5  one-hot phase: FETCH 10000, DECODE 01000, EXEC 00100, MEM 00010, WB 00001; IDLE 00000.
- ir_load  out  1  instr is being latched into IR.
- reg_a / reg_b  out  REG_AW each  IR fields ra and rb.
- imm  out  IMM_W  IR low IMM_W bits, fed to the sign extender.
- jump_target  out  INSTR_W-4  IR low INSTR_W-4 bits.
- reg_r_enable, reg_w_enable, alu_mux, sign_mux, write_data_mux, disp_enable, mem_r_enable, mem_w_enable  out  1 each.
- pc_enables  out  3  one-hot PC source: 100 branch, 010 increment, 001 jump, 000 hold.
- alu_op  out  4  ALU operation.
- instr_done  out  1  one-cycle pulse in WB.
- retired_count  out  CNT_W  number of completed instructions.

## Operation
Instruction fields:
- opcode = IR[INSTR_W-1 -: 4]
- ra = next REG_AW bits
- rb = next REG_AW bits
- rcode = IR[3:0]

Decode from IR (opcode → alu_op, alu_mux):
- 0 R-type → rcode, alu_mux 0
- 1 addi → 0001
- 2 movi → 0000
- 3 andi → 1100
- 4 ori → 1101
- 5 xori → 1110
- 6 sli → 0111
- 7 sri → 0110
- 8 srli → 1001
- 9 disp → 1010
- A beqz → 0101
- B bgtz → 0100
- C bltz → 1011
- D lw ra,(rb) → 0000, alu_mux 0
- E sw ra,(rb) → 0000, alu_mux 0
- F jump → 0000

Decode rules:
- alu_mux is 1 for opcodes 1–C.
- sign_mux is 0 for A/B/C and 1 otherwise.
- alu_op, alu_mux and sign_mux are driven from DECODE through WB and are 0 in IDLE and FETCH.

State machine:
- IDLE → FETCH when enable=1.
- FETCH: waits for instr_valid. When instr_valid=1, ir_load=1 combinationally, IR captures instr, and the next state is DECODE.
- DECODE (1 cycle): reg_r_enable=1 unless the opcode is F.
- EXEC (1 cycle): at the clock edge leaving EXEC, cond_flag ← alu_out0.
- MEM:
  - lw: mem_r_enable=1. sw: mem_w_enable=1.
  - Held while mem_ready=0. The state advances to WB on the first edge where mem_ready=1.
  - All other opcodes spend exactly 1 cycle in MEM and ignore mem_ready.
- WB (1 cycle):
  - instr_done=1 and retired_count increments. The counter wraps modulo 2^CNT_W.
  - reg_w_enable=1 for opcodes 0–8 and D.
  - write_data_mux=1 for D only; otherwise 0.
  - disp_enable=1 for opcode 9.
  - pc_enables: A/B/C → cond_flag ? 100 : 010; F → 001; all others → 010.
  - Next state is FETCH if enable=1, else IDLE.

Other rules:
- Every enable, pc_enables and instr_done is 0 outside the phase listed above. Each is a pure function of state and IR, except ir_load, which also depends on instr_valid.
- Deasserting enable mid-instruction does not abort; the current instruction completes through WB.
- All 16 opcodes are defined; there is no illegal-instruction state.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, IR=0, cond_flag=0, retired_count=0.
  - All outputs 0; phase=00000.
- Latency with instr_valid=1 and mem_ready=1 at first opportunity: 5 cycles per instruction (FETCH…WB).
- Each cycle with instr_valid=0 in FETCH adds one cycle; each cycle with mem_ready=0 in MEM during lw/sw adds one cycle.
- Back-to-back instructions with enable held high: WB is followed directly by FETCH, with no IDLE cycle.
- Reset asserted during MEM with mem_w_enable=1: mem_w_enable drops asynchronously. The aborted instruction does not count.
- mem_ready=1 outside the MEM phase of lw/sw is ignored.

## Test plan
- Reset, then enable=1, instr=0x1305 (addi r3,5), instr_valid=1 → phase sequence 10000,01000,00100,00010,00001. In EXEC: alu_op=0001, alu_mux=1. In WB: reg_w_enable=1, pc_enables=010, instr_done=1, retired_count=1.
- instr=0xA200 (beqz r2) with alu_out0=1 in EXEC → WB pc_enables=100 and reg_w_enable=0. Repeat with alu_out0=0 → pc_enables=010.
- instr=0xD140 (lw r1,(r4)), mem_ready low for 3 MEM cycles → mem_r_enable high for 4 cycles. Then WB: write_data_mux=1, reg_w_enable=1. Total 8 cycles.
- instr=0xF123 → jump_target=0x123, reg_r_enable=0 in DECODE, WB pc_enables=001, no register write. instr=0x9500 (disp) → WB disp_enable=1, alu_op=1010.
- Hold instr_valid=0 for 2 FETCH cycles → ir_load and IR unchanged until instr_valid=1. Drop enable during EXEC → instruction finishes WB, then phase=00000.
- instr=0xE340 (sw); assert rst_n=0 in MEM → mem_w_enable=0 immediately, phase=00000, retired_count unchanged at 0.
